// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: 1-bit full adder
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands one bit per cycle, LSB first, through a single full adder
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;
    full_adder u_fa (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .c_in (carry),
        .sum  (fa_sum),
        .c_out(fa_cout)
    );
    assign ready = state == IDLE;
    assign busy  = state == SHIFT;
    assign done  = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q   <= a;
                    b_q   <= b;
                    carry <= c_in;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    // result bits enter at the MSB so the LSB lands in place after WIDTH shifts
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    carry <= fa_cout;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        c_out <= fa_cout;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the 8-bit serial adder
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       c_in = 1'b0;
    logic       ready, busy, done, c_out;
    logic [7:0] sum;
    int total = 0, bad = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .c_out(c_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic [7:0] es, input logic ec, input bit inject);
        int n, nb, nr;
        @(negedge clk);
        check({tag, "_ready"}, ready, 1);
        a = av; b = bv; c_in = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = 8'h77; c_in = ~ci;
        n = 0; nb = 0; nr = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            if (ready) nr++;
            if (inject) begin
                start = (n == 3);
                if (n == 3) begin a = 8'hFF; b = 8'hFF; end
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_cycles"}, nb, 8);
        check({tag, "_ready_low"}, nr, 0);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, c_out, ec);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, ready, 1);
        @(negedge clk);
        check({tag, "_no_restart"}, busy, 0);
        check({tag, "_sum_hold"}, sum, es);
    endtask

    initial begin
        int n, pulses, last, nd;
        rst = 1'b1;
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);
        #13 rst = 1'b0;
        do_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        do_add("add3c0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
        do_add("ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_add("cin", 8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0);
        do_add("inject", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);
        // continuous start: one operation per WIDTH+2 cycles
        @(negedge clk);
        a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
        pulses = 0; last = 0; n = 0;
        while (pulses < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                check("hold_sum", sum, 8'h46);
                check("hold_cout", c_out, 0);
                if (pulses > 0) check("hold_period", n - last, 10);
                last = n;
                pulses++;
            end
        end
        start = 1'b0;
        check("hold_pulses", pulses, 3);
        repeat (2) @(negedge clk);
        // asynchronous reset mid-SHIFT, between clock edges
        a = 8'h3C; b = 8'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", ready, 1);
        check("arst_busy", busy, 0);
        check("arst_sum", sum, 0);
        check("arst_cout", c_out, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("arst_no_done", nd, 0);
        do_add("post_rst", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 It SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 Port start, input, 1 bit: request to begin an addition; sampled only when ready=1.
REQ-006 Port a, input, WIDTH bits: operand A; captured on an accepted start.
REQ-007 Port b, input, WIDTH bits: operand B; captured on an accepted start.
REQ-008 Port c_in, input, 1 bit: carry-in; captured on an accepted start.
REQ-009 Port ready, output, 1 bit: high only in IDLE; the block accepts start.
REQ-010 Port busy, output, 1 bit: high only in SHIFT.
REQ-011 Port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-012 Port sum, output, WIDTH bits: registered result, A+B+c_in modulo 2^WIDTH.
REQ-013 Port c_out, output, 1 bit: registered carry-out of the WIDTH-bit addition.

Function
REQ-014 The block SHALL have a state machine with states IDLE, SHIFT and DONE.
REQ-015 In IDLE, start=1 at a rising edge SHALL capture a, b and c_in into shift and carry registers, clear the bit counter and go to SHIFT.
REQ-016 In SHIFT, each cycle SHALL add the operand LSBs and the carry register in one full adder, shift the sum bit into sum from the MSB side, load the new carry into the carry register, shift both operands right one bit and increment the counter.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; after the WIDTH-th bit, the state SHALL go to DONE.
REQ-018 On entry to DONE, sum SHALL hold the full result, c_out SHALL equal the final carry and done SHALL be 1 for exactly one cycle.
REQ-019 DONE SHALL go to IDLE unconditionally on the next edge.
REQ-020 Latency: an accepted start at edge k SHALL make done high in the cycle after edge k+WIDTH.
REQ-021 sum and c_out SHALL hold their values from DONE until the next accepted start updates them.
REQ-022 start SHALL be ignored in SHIFT and DONE, and SHALL NOT alter the operation in progress.
REQ-023 Changes on a, b and c_in after capture SHALL NOT affect the operation in progress.
REQ-024 start held high continuously SHALL start a new operation on each return to IDLE: one operation every WIDTH+2 cycles.
REQ-025 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-026 Asserting rst SHALL, immediately and regardless of clk, set the state to IDLE.
REQ-027 Asserting rst SHALL, immediately and regardless of clk, clear sum, c_out, the carry register, the operand registers and the counter to 0.
REQ-028 Output values under reset: ready=1, busy=0, done=0.
REQ-029 A reset during SHIFT or DONE SHALL abandon the operation without a done pulse.
REQ-030 The first start SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-031 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL be defined in the shared package serial_adder_pkg.
REQ-032 The default WIDTH constant SHALL be defined in serial_adder_pkg.
REQ-033 The per-bit addition SHALL be one instance of the team's 1-bit full_adder sub-module.
REQ-034 The full_adder ports SHALL be x, y, c_in, sum and c_out.
REQ-035 serial_adder SHALL contain no other arithmetic.

Verification (WIDTH=8)
REQ-036 a=0x00, b=0x00, c_in=0, start pulse -> done after 8 SHIFT cycles; sum=0x00, c_out=0.
REQ-037 a=0x3C, b=0x0F, c_in=0 -> sum=0x4B, c_out=0; a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1.
REQ-038 a=0x5A, b=0xA5, c_in=1 -> sum=0x00, c_out=1; busy high exactly 8 cycles; done high exactly 1 cycle.
REQ-039 start with a=0x10, b=0x20, c_in=0, then start pulse with a=0xFF, b=0xFF during SHIFT -> first result sum=0x30, c_out=0 unaffected; second request ignored; ready=0 throughout.
REQ-040 start held high with constant operands -> done pulses every 10 cycles with identical results.
REQ-041 rst asserted at SHIFT cycle 4, between clock edges -> ready=1 at once; sum=0, c_out=0; no done pulse; a following start gives a correct result.
